// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared Booth FSM states, digit codes and radix-4 recoding helper
// Contents:
//   state_t       S_IDLE, S_CALC, S_DONE
//   digit_t       D_ZERO, D_P1, D_P2, D_M1, D_M2
//   booth_decode  maps a multiplier bit triplet {q[i+1], q[i], q[i-1]} to a digit code
package booth_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      D_ZERO = 3'd0,
      D_P1   = 3'd1,
      D_P2   = 3'd2,
      D_M1   = 3'd3,
      D_M2   = 3'd4
   } digit_t;

   function automatic digit_t booth_decode(input logic [2:0] triplet);
      case (triplet)
         3'b001, 3'b010: return D_P1;
         3'b011:         return D_P2;
         3'b100:         return D_M2;
         3'b101, 3'b110: return D_M1;
         default:        return D_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/booth_r4_digit_sel.sv
// rtl/booth_r4_digit_sel.sv - radix-4 Booth partial product selector (combinational)
// Ports:
//   triplet  in   3             current multiplier bits {q[2], q[1], q[0]}
//   m        in   DATA_WIDTH+2  sign-extended multiplicand
//   pp       out  DATA_WIDTH+2  signed partial product: 0, +M, +2M, -M or -2M
module booth_r4_digit_sel
   import booth_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [2:0]            triplet,
   input  logic [DATA_WIDTH+1:0] m,
   output logic [DATA_WIDTH+1:0] pp
);

   localparam int W = DATA_WIDTH + 2;
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] m2;

   // m carries two sign bits, so dropping the top one to double it loses nothing
   assign m2 = {m[W-2:0], 1'b0};

   always_comb begin
      pp = '0;
      case (booth_decode(triplet))
         D_P1:    pp = m;
         D_P2:    pp = m2;
         D_M1:    pp = ~m + ONE;
         D_M2:    pp = ~m2 + ONE;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth signed multiplier, 2 bits per clock
// Ports:
//   clk    in   1           clock, all state on posedge
//   rst    in   1           synchronous active-high reset
//   start  in   1           request, sampled only in IDLE
//   a      in   DATA_WIDTH  signed multiplicand, captured on accept
//   b      in   DATA_WIDTH  signed multiplier, captured on accept
//   c      out  OUT_WIDTH   product, held until the next done
//   done   out  1           one-cycle pulse, c valid in that cycle
//   busy   out  1           high from accept until the result is written
module booth_r4_seq_mult
   import booth_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [OUT_WIDTH-1:0]  c,
   output logic                  done,
   output logic                  busy
);

   localparam int W  = DATA_WIDTH + 2;
   localparam int N  = DATA_WIDTH / 2;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_width
      $error("booth_r4_seq_mult: DATA_WIDTH must be even and >= 4");
   end

   state_t                state;
   logic [W-1:0]          m_reg;
   logic [W-1:0]          p_reg;
   logic [DATA_WIDTH:0]   q_reg;
   logic [CW-1:0]         count;
   logic [W-1:0]          pp;
   logic [W-1:0]          sum;
   logic signed [W+DATA_WIDTH-1:0] product;

   booth_r4_digit_sel #(.DATA_WIDTH(DATA_WIDTH)) u_digit_sel (
      .triplet (q_reg[2:0]),
      .m       (m_reg),
      .pp      (pp)
   );

   assign sum = p_reg + pp;

   // q_reg[0] ends up holding the multiplier's old sign bit, so the low half starts at bit 1
   assign product = {p_reg, q_reg[DATA_WIDTH:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         c     <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
         count <= '0;
         m_reg <= '0;
         p_reg <= '0;
         q_reg <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  m_reg <= {{2{a[DATA_WIDTH-1]}}, a};
                  p_reg <= '0;
                  q_reg <= {b, 1'b0};
                  count <= '0;
                  busy  <= 1'b1;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               // arithmetic shift of {P+digit, Q} right by two
               p_reg <= {{2{sum[W-1]}}, sum[W-1:2]};
               q_reg <= {sum[1:0], q_reg[DATA_WIDTH:2]};
               count <= count + CW'(1);
               if (count == LAST) state <= S_DONE;
            end
            S_DONE: begin
               c     <= OUT_WIDTH'(product);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - self-checking bench for booth_r4_seq_mult
module tb_booth_r4_seq_mult;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] c;
   logic        done;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   booth_r4_seq_mult #(.DATA_WIDTH(16), .OUT_WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c),
      .done  (done),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return p[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // wait for done, returning edges counted; bounded at 50
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      int pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (done) pulses++;
      end
      check(tag, 64'(pulses), 64'd0);
   endtask

   // one full multiply from IDLE, checking latency, result and pulse width
   task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp);
      int lat;
      a = x;
      b = y;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      wait_done(lat);
      check({tag, "_lat"}, 64'(lat), 64'd9);
      check({tag, "_c"}, 64'(c), 64'(exp));
   endtask

   initial begin
      int lat;
      int busy_low;
      logic [15:0] x;
      logic [15:0] y;

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_c", 64'(c), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      watch_no_done("idle_no_done", 20);

      // basic 3*5 with busy tracking
      a = 16'd3;
      b = 16'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2_busy_after_accept", 64'(busy), 64'd1);
      lat = 0;
      busy_low = 0;
      while (!done && lat < 50) begin
         if (!busy) busy_low++;
         tick();
         lat++;
      end
      check("t2_busy_held", 64'(busy_low), 64'd0);
      check("t2_lat", 64'(lat), 64'd9);
      check("t2_c", 64'(c), 64'h0000000F);
      tick();
      check("t2_done_one_cycle", 64'(done), 64'd0);
      check("t2_c_holds", 64'(c), 64'h0000000F);

      run_op("neg7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6);
      run_op("minxmin", 16'h8000, 16'h8000, 32'h40000000);
      run_op("maxxmin", 16'h7FFF, 16'h8000, 32'hC0008000);
      run_op("zeroxm1", 16'd0, 16'hFFFF, 32'h00000000);

      // second request during CALC is ignored
      a = 16'd100;
      b = 16'd100;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a = 16'd1;
      b = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      check("t4_lat", 64'(lat), 64'd6);
      check("t4_c", 64'(c), 64'h00002710);
      watch_no_done("t4_no_second", 15);

      // reset mid-operation
      a = 16'd9;
      b = 16'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_c_cleared", 64'(c), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_done", 64'(done), 64'd0);
      watch_no_done("t5_no_done", 15);
      run_op("t5_after", 16'd2, 16'd3, 32'd6);

      // back-to-back with start held high
      a = 16'd2;
      b = 16'd3;
      start = 1'b1;
      tick();
      a = 16'd4;
      b = 16'd5;
      wait_done(lat);
      check("t6_first_lat", 64'(lat), 64'd9);
      check("t6_first_c", 64'(c), 64'd6);
      tick();
      start = 1'b0;
      lat = 1;
      while (!done && lat < 50) begin
         tick();
         lat++;
      end
      check("t6_period", 64'(lat), 64'd10);
      check("t6_second_c", 64'(c), 64'd20);

      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         case ($urandom_range(0, 9))
            0: x = 16'h8000;
            1: y = 16'h7FFF;
            2: y = 16'hFFFF;
            default: ;
         endcase
         run_op("rand", x, y, ref_mul(x, y));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
